// File: rtl/btn_sync_debounce_pkg.sv
// Shared definitions for the push-button front end: button bit indices,
// build defaults and the prescaler divide helper.
package btn_sync_debounce_pkg;

  // Bit positions of the board buttons inside the iBtnRaw/oBtn vectors.
  typedef enum int {
    SW_LEFT   = 0,
    SW_RIGHT  = 1,
    SW_UP     = 2,
    SW_DOWN   = 3,
    SW_JUMP   = 4,
    SW_CENTER = 5,
    SW_COUNT  = 6
  } sw_idx_e;

  localparam int SYS_CLK_HZ_DEF  = 100_000_000;
  localparam int TICK_HZ_DEF     = 1000;
  localparam int DEBOUNCE_MS_DEF = 10;
  localparam int CNT_W           = 8;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } db_state_e;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, polarity normalisation and the
// STABLE/CHANGING debounce FSM that owns the debounced output bit.
module btn_debounce_ch
  import btn_sync_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iTick,
  input  logic iRaw,
  output logic oBtn
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            level_p1;
  db_state_e       state;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: synchroniser, reset to the released pin level
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sync_p0 <= ACTIVE_LOW;
      sync_p1 <= ACTIVE_LOW;
    end else begin
      sync_p0 <= iRaw;
      sync_p1 <= sync_p0;
    end
  end

  assign level_p1 = sync_p1 ^ ACTIVE_LOW;

  // Debounce FSM: a bounce back to the held level is checked before the tick,
  // so a bounce coinciding with the accepting tick cancels the accept.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= ST_STABLE;
      cnt   <= '0;
      oBtn  <= 1'b0;
    end else begin
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (level_p1 != oBtn) begin
            state <= ST_CHANGING;
          end
        end
        ST_CHANGING: begin
          if (level_p1 == oBtn) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (iTick) begin
            if (cnt == CNT_LAST) begin
              oBtn  <= level_p1;
              cnt   <= '0;
              state <= ST_STABLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_sync_debounce.sv
// Button front end: 1 ms strobe prescaler, per-button debounce channels and
// an optional press-pulse edge detector enabled by BTN_PRESS_PULSE_EN.
module btn_sync_debounce
  import btn_sync_debounce_pkg::*;
#(
  parameter int SYS_CLK_HZ     = SYS_CLK_HZ_DEF,
  parameter int TICK_HZ        = TICK_HZ_DEF,
  parameter int BTN_NUM        = SW_COUNT,
  parameter int DEBOUNCE_MS    = DEBOUNCE_MS_DEF,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [BTN_NUM-1:0] iBtnRaw,
  output logic [BTN_NUM-1:0] oBtn,
  output logic [BTN_NUM-1:0] oBtnPress,
  output logic               oEn1Ms
);

  localparam int TICK_DIV = tick_div(SYS_CLK_HZ, TICK_HZ);
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_p0;

  // Stage p0: prescaler; the strobe is registered so it lands one cycle after the wrap
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      presc_p0 <= '0;
      oEn1Ms   <= 1'b0;
    end else begin
      oEn1Ms   <= (presc_p0 == PRESC_LAST);
      presc_p0 <= (presc_p0 == PRESC_LAST) ? '0 : presc_p0 + PRESC_W'(1);
    end
  end

  // All channels share the registered strobe as their debounce tick
  for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .ACTIVE_LOW  (BTN_ACTIVE_LOW != 0)
    ) u_ch (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .iTick (oEn1Ms),
      .iRaw  (iBtnRaw[gi]),
      .oBtn  (oBtn[gi])
    );
  end

`ifdef BTN_PRESS_PULSE_EN
  logic [BTN_NUM-1:0] btn_q_p1;

  // Stage p1: rising-edge detect on the debounced level, pulse one cycle after the rise
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      btn_q_p1  <= '0;
      oBtnPress <= '0;
    end else begin
      btn_q_p1  <= oBtn;
      oBtnPress <= oBtn & ~btn_q_p1;
    end
  end
`else
  assign oBtnPress = '0;
`endif

endmodule

// File: tb/tb_btn_sync_debounce.sv
// Bench for btn_sync_debounce: run-length debounce model plus directed scenarios.
module tb_btn_sync_debounce;

  localparam int N   = 6;
  localparam int DIV = 10;
  localparam int DB  = 3;
`ifdef BTN_PRESS_PULSE_EN
  localparam bit PRESS_ON = 1'b1;
`else
  localparam bit PRESS_ON = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw   = '1;
  logic [N-1:0] btn;
  logic [N-1:0] btn_press;
  logic         en_1ms;

  int checks   = 0;
  int failures = 0;

  // Model state: k = clock edges since reset release
  int           k = 0;
  logic [N-1:0] m_btn   = '0;
  logic [N-1:0] m_prev  = '0;
  logic [N-1:0] m_press = '0;
  int           run_start [N];
  logic [N-1:0] raw_log [16];

  btn_sync_debounce #(
    .SYS_CLK_HZ     (10_000),
    .TICK_HZ        (1000),
    .BTN_NUM        (N),
    .DEBOUNCE_MS    (DB),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iBtnRaw   (raw),
    .oBtn      (btn),
    .oBtnPress (btn_press),
    .oEn1Ms    (en_1ms)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int n, input int lo, input int hi);
    checks++;
    if (n < lo || n > hi) begin
      failures++;
      $display("FAIL %s: got %0d cycles expected %0d..%0d", name, n, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bit(input int b, input logic v, input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (btn[b] == v) begin
        n = c;
        break;
      end
    end
  endtask

  // Model: a channel accepts a new level once the synchronised (2-edge delayed)
  // level has differed from the output on every edge since run start s and
  // DB strobes have been consumed after s; strobes are seen at edges 11, 21, ...
  initial begin
    for (int i = 0; i < N; i++) run_start[i] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k       = 0;
        m_btn   = '0;
        m_prev  = '0;
        m_press = '0;
        for (int i = 0; i < N; i++) run_start[i] = 0;
      end else begin
        k++;
        raw_log[k % 16] = raw;
        m_press = m_btn & ~m_prev;
        m_prev  = m_btn;
        for (int i = 0; i < N; i++) begin
          logic lvl;
          lvl = (k >= 3) ? ~raw_log[(k - 2) % 16][i] : 1'b0;
          if (lvl == m_btn[i]) begin
            run_start[i] = 0;
          end else if (run_start[i] == 0) begin
            run_start[i] = k;
          end else if ((k - 1) / DIV - (run_start[i] - 1) / DIV >= DB) begin
            m_btn[i]     = lvl;
            run_start[i] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && k > 0) begin
        chk("cyc_btn", btn, m_btn);
        chk("cyc_en", en_1ms, (k % DIV == 0));
        chk("cyc_press", btn_press, PRESS_ON ? m_press : '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int strobes;
    rst_n = 1'b0;
    raw   = '1;
    cyc(4);
    chk("rst_btn", btn, 0);
    chk("rst_en", en_1ms, 0);
    chk("rst_press", btn_press, 0);
    rst_n = 1'b1;

    // Strobe timing and idle outputs
    cyc(9);  chk("s1_en_c9", en_1ms, 0);
    cyc(1);  chk("s1_en_c10", en_1ms, 1);
    cyc(1);  chk("s1_en_c11", en_1ms, 0);
    cyc(9);  chk("s1_en_c20", en_1ms, 1);
    cyc(15); chk("s1_btn_idle", btn, 0);

    // Clean press of bit 0
    raw[0] = 1'b0;
    wait_bit(0, 1'b1, 40, n);
    chk_range("s2_latency", n, 23, 33);
    cyc(1); chk("s2_press", btn_press, PRESS_ON ? 1 : 0);
    cyc(1); chk("s2_press_end", btn_press, 0);

    // Release: falls after a full debounce, no pulse
    raw[0] = 1'b1;
    wait_bit(0, 1'b0, 40, n);
    chk_range("s4_latency", n, 23, 33);
    cyc(1); chk("s4_no_press", btn_press, 0);

    // Bouncing input every 7 cycles never accepted
    for (int t = 0; t < 14; t++) begin
      raw[0] = ~raw[0];
      cyc(7);
    end
    cyc(40);
    chk("s3_bounce_btn", btn, 0);

    // Bits 0 and 5 together
    raw = 6'b011110;
    wait_bit(0, 1'b1, 40, n);
    chk_range("s5_latency", n, 23, 33);
    chk("s5_both", btn, 6'b100001);

    // Reset in the middle of a debounce with bit 5 held
    raw[0] = 1'b1;
    wait_bit(0, 1'b0, 40, n);
    chk("s6_pre", btn, 6'b100000);
    raw[0]  = 1'b0;
    strobes = 0;
    for (int c = 0; c < 40 && strobes < 2; c++) begin
      @(negedge clk);
      if (en_1ms) strobes++;
    end
    chk("s6_two_ticks", strobes, 2);
    chk("s6_mid", btn, 6'b100000);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_btn", btn, 0);
    chk("s6_rst_en", en_1ms, 0);
    chk("s6_rst_press", btn_press, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(30); chk("s6_hold_c30", btn, 0);
    cyc(1);  chk("s6_accept_c31", btn, 6'b100001);
    cyc(1);  chk("s6_press_c32", btn_press, PRESS_ON ? 6'b100001 : 0);

    raw = '1;
    cyc(40);
    chk("end_btn", btn, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
